// File: rtl/row_matrix_streamer.sv
// row_matrix_streamer
//   Row-addressed matrix store with a burst read engine. Rows are written one
//   per cycle; a single command streams a run of consecutive rows (ascending or
//   descending, wrapping modulo NUM_ROWS) under valid/ready backpressure at
//   full throughput despite the row memory's read latency.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   write_row_addr/
//   write_data/
//   write_ready        row write strobe (always accepted, even mid-burst)
//   start/first_row/
//   num_rows/reverse   burst command, accepted when start && cmd_ready
//   abort              flushes the active burst, engine idle next cycle
//   cmd_ready          engine idle
//   row_valid/out_ready stream handshake
//   row_out/row_index/
//   row_last           streamed row, its memory row and end-of-burst flag
//                      (all zero while row_valid=0)
module row_matrix_streamer #(
  parameter int NUM_ROWS       = 3,
  parameter int NUM_COLS       = 5,
  parameter int SCALAR_BITS    = 32,
  parameter int MEMORY_LATENCY = 2,
  localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int ROW_SIZE       = NUM_COLS * SCALAR_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
  input  logic [ROW_SIZE-1:0]       write_data,
  input  logic                      write_ready,
  input  logic                      start,
  input  logic [ROW_ADDR_WIDTH-1:0] first_row,
  input  logic [ROW_ADDR_WIDTH:0]   num_rows,
  input  logic                      reverse,
  input  logic                      abort,
  output logic                      cmd_ready,
  output logic                      row_valid,
  input  logic                      out_ready,
  output logic [ROW_SIZE-1:0]       row_out,
  output logic [ROW_ADDR_WIDTH-1:0] row_index,
  output logic                      row_last
);

  localparam int FIFO_DEPTH = MEMORY_LATENCY + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(2 * FIFO_DEPTH + 1);

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [PTR_W-1:0]          LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ROW_ADDR_WIDTH:0]   ONE_ROW  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ROW_ADDR_WIDTH:0]   remain_q, remain_d;
  logic                      rev_q, rev_d;

  logic [ROW_SIZE-1:0] mem [NUM_ROWS];

  // In-flight read slots; stage MEMORY_LATENCY-1 holds data returned by memory.
  logic [MEMORY_LATENCY-1:0] pv_q;
  logic [MEMORY_LATENCY-1:0] plast_q;
  logic [ROW_ADDR_WIDTH-1:0] pidx_q  [MEMORY_LATENCY];
  logic [ROW_SIZE-1:0]       pdata_q [MEMORY_LATENCY];

  // Show-ahead output FIFO.
  logic [ROW_SIZE-1:0]       fdata_q [FIFO_DEPTH];
  logic [ROW_ADDR_WIDTH-1:0] fidx_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     flast_q;
  logic [PTR_W-1:0]          wptr_q, rptr_q;
  logic [CNT_W-1:0]          fcnt_q;

  logic                      issue, issue_last, push, pop, credit;
  logic [CNT_W-1:0]          inflight;
  logic [ROW_ADDR_WIDTH-1:0] next_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign row_valid = (fcnt_q != '0);
  assign row_out   = row_valid ? fdata_q[rptr_q] : '0;
  assign row_index = row_valid ? fidx_q[rptr_q] : '0;
  assign row_last  = row_valid && flast_q[rptr_q];
  assign cmd_ready = (state_q == S_IDLE);

  assign pop        = row_valid && out_ready;
  assign push       = pv_q[MEMORY_LATENCY-1] && !abort;
  assign issue_last = (remain_q == ONE_ROW);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MEMORY_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pv_q[i]);
    end
  end

  // Every in-flight slot is guaranteed a FIFO entry; a pop this cycle frees one.
  assign credit = (inflight + fcnt_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);

  always_comb begin
    next_addr = '0;
    if (rev_q) begin
      next_addr = (addr_q == '0) ? LAST_ROW : addr_q - 1'b1;
    end else begin
      next_addr = (addr_q == LAST_ROW) ? '0 : addr_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    rev_d    = rev_q;
    issue    = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      remain_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (num_rows != '0)) begin
            addr_d   = first_row;
            remain_d = num_rows;
            rev_d    = reverse;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (credit) begin
            issue    = 1'b1;
            addr_d   = next_addr;
            remain_d = remain_q - 1'b1;
            if (issue_last) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && row_last) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      rev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      rev_q    <= rev_d;
    end
  end

  // Write and read share an edge, so a same-cycle write is not seen by the read.
  always_ff @(posedge clk) begin
    if (write_ready && (write_row_addr <= LAST_ROW)) begin
      mem[write_row_addr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pdata_q[0] <= mem[addr_q];
    end
    for (int unsigned i = 1; i < MEMORY_LATENCY; i++) begin
      pdata_q[i] <= pdata_q[i-1];
    end
    if (push) begin
      fdata_q[wptr_q] <= pdata_q[MEMORY_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q    <= '0;
      plast_q <= '0;
      for (int unsigned i = 0; i < MEMORY_LATENCY; i++) begin
        pidx_q[i] <= '0;
      end
    end else begin
      pv_q[0]    <= issue && !abort;
      plast_q[0] <= issue_last;
      pidx_q[0]  <= addr_q;
      for (int unsigned i = 1; i < MEMORY_LATENCY; i++) begin
        pv_q[i]    <= pv_q[i-1] && !abort;
        plast_q[i] <= plast_q[i-1];
        pidx_q[i]  <= pidx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      flast_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fidx_q[i] <= '0;
      end
    end else if (abort) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        fidx_q[wptr_q]  <= pidx_q[MEMORY_LATENCY-1];
        flast_q[wptr_q] <= plast_q[MEMORY_LATENCY-1];
        wptr_q          <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      fcnt_q <= fcnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
